// File: rtl/vga_timing_pkg.sv
// Shared timing constants, coordinate types and helpers for the VGA sync generator.
// Defaults describe 640x480 at 31.5 MHz with an 832 x 520 total raster.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 24;
    localparam int H_SYNC    = 40;
    localparam int H_BACK    = 128;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 9;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 28;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so region boundaries equal to 1024 do not wrap to zero.
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef enum logic [1:0] {
        REG_VISIBLE,
        REG_FRONT,
        REG_SYNC,
        REG_BACK
    } axis_region_e;

    function automatic axis_region_e region_of(
        input coord_t     c,
        input coord_ext_t vis_end,
        input coord_ext_t sync_beg,
        input coord_ext_t sync_end
    );
        coord_ext_t ce;
        ce = {1'b0, c};
        if (ce < vis_end)  return REG_VISIBLE;
        if (ce < sync_beg) return REG_FRONT;
        if (ce < sync_end) return REG_SYNC;
        return REG_BACK;
    endfunction

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from the sync generator to pixel and frame-rate consumers.
interface vga_sync_gen_if
    import vga_timing_pkg::*;
;
    logic   hsync;
    logic   vsync;
    coord_t x_px;
    coord_t y_px;
    logic   activevideo;
    logic   frame_start;

    modport master (
        output hsync,
        output vsync,
        output x_px,
        output y_px,
        output activevideo,
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input x_px,
        input y_px,
        input activevideo,
        input frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus classification of the value
// it will hold after the next edge, so the parent can register aligned flags.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int VISIBLE    = H_VISIBLE,
    parameter int SYNC_START = H_VISIBLE + H_FRONT,
    parameter int SYNC_WIDTH = H_SYNC
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   enable,
    output coord_t count,
    output logic   wrap,
    output logic   visible_next,
    output logic   sync_next
);

    localparam coord_t     LAST     = coord_t'(TOTAL - 1);
    localparam coord_ext_t VIS_END  = coord_ext_t'(VISIBLE);
    localparam coord_ext_t SYNC_BEG = coord_ext_t'(SYNC_START);
    localparam coord_ext_t SYNC_END = coord_ext_t'(SYNC_START + SYNC_WIDTH);

    coord_t       count_next;
    axis_region_e region_next;

    always_comb begin
        wrap         = enable && (count == LAST);
        count_next   = count;
        if (enable) begin
            count_next = (count == LAST) ? '0 : count + coord_t'(1);
        end
        region_next  = region_of(count_next, VIS_END, SYNC_BEG, SYNC_END);
        visible_next = (region_next == REG_VISIBLE);
        sync_next    = (region_next == REG_SYNC);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: x/y counters with registered sync, active-video
// and frame-start flags aligned to the coordinates they describe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input logic           clk,
    input logic           reset_n,
    vga_sync_gen_if.master vid
);

    localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    coord_t x_cnt;
    coord_t y_cnt;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_visible_next;
    logic   v_visible_next;
    logic   h_sync_next;
    logic   v_sync_next;

    logic   hsync_q;
    logic   vsync_q;
    logic   active_q;
    logic   frame_start_q;

    vga_axis_counter #(
        .TOTAL      (LINE_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_WIDTH (H_SYNC)
    ) u_h_axis (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (1'b1),
        .count        (x_cnt),
        .wrap         (h_wrap),
        .visible_next (h_visible_next),
        .sync_next    (h_sync_next)
    );

    vga_axis_counter #(
        .TOTAL      (FRAME_LINES),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_WIDTH (V_SYNC)
    ) u_v_axis (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (h_wrap),
        .count        (y_cnt),
        .wrap         (v_wrap),
        .visible_next (v_visible_next),
        .sync_next    (v_sync_next)
    );

    // v_wrap already implies h_wrap, so it marks exactly the edge into (0,0);
    // the reset-held (0,0) never pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= sync_level(h_sync_next, SYNC_POL);
            vsync_q       <= sync_level(v_sync_next, SYNC_POL);
            active_q      <= h_visible_next && v_visible_next;
            frame_start_q <= v_wrap;
        end
    end

    assign vid.x_px        = x_cnt;
    assign vid.y_px        = y_cnt;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.activevideo = active_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for line-level behaviour, plus a tiny
// 16x10 raster with active-high syncs for whole-frame and reset corner cases.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct {
        string name;
        logic  rst_n;
        int    edges;
        int    x;
        int    y;
        logic  hs;
        logic  vs;
        logic  av;
        logic  fs;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_d_n = 1'b0;
    logic rst_s_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    vga_sync_gen_if if_d ();
    vga_sync_gen_if if_s ();

    vga_sync_gen dut_d (
        .clk     (clk),
        .reset_n (rst_d_n),
        .vid     (if_d)
    );

    vga_sync_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (6),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1),
        .SYNC_POL  (1'b1)
    ) dut_s (
        .clk     (clk),
        .reset_n (rst_s_n),
        .vid     (if_s)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic r, input int e,
                                input int x, input int y,
                                input logic hs, input logic vs,
                                input logic av, input logic fs);
        vec_t v;
        v.name = n; v.rst_n = r; v.edges = e; v.x = x; v.y = y;
        v.hs = hs; v.vs = vs; v.av = av; v.fs = fs;
        return v;
    endfunction

    function automatic logic [23:0] pack(input int x, input int y, input logic hs,
                                         input logic vs, input logic av, input logic fs);
        logic [9:0] xs;
        logic [9:0] ys;
        xs = x[9:0];
        ys = y[9:0];
        return {xs, ys, hs, vs, av, fs};
    endfunction

    function automatic logic [23:0] act_d();
        return {if_d.x_px, if_d.y_px, if_d.hsync, if_d.vsync, if_d.activevideo, if_d.frame_start};
    endfunction

    function automatic logic [23:0] act_s();
        return {if_s.x_px, if_s.y_px, if_s.hsync, if_s.vsync, if_s.activevideo, if_s.frame_start};
    endfunction

    task automatic applyStimulus(input logic rst_val, input int edges);
        rst_d_n = rst_val;
        repeat (edges) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got x=%0d y=%0d hs=%b vs=%b av=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b av=%b fs=%b",
                     name, act[23:14], act[13:4], act[3], act[2], act[1], act[0],
                     exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   low_cnt, low_first, low_last, av_cnt;
        int   fs_first, fs_second, fs_cnt, vs_cnt;
        int   mx, my;

        // Default timing, hsync/vsync active-low: edge counts are cumulative.
        vecs.push_back(mk("reset3",   1'b0,   3,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("release",  1'b1,   1,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("x639",     1'b1, 638, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("x640",     1'b1,   1, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("x663",     1'b1,  23, 663, 0, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("x664",     1'b1,   1, 664, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("x703",     1'b1,  39, 703, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("x704",     1'b1,   1, 704, 0, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("x831",     1'b1, 127, 831, 0, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("line1",    1'b1,   1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("x5y1",     1'b1,   5,   5, 1, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("midrst",   1'b0,   1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("postrst",  1'b1,   1,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].edges);
            checkOutput(vecs[i].name, act_d(),
                        pack(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].av, vecs[i].fs));
        end

        // One full line on the default instance: hsync window and visible width.
        low_cnt = 0; low_first = -1; low_last = -1; av_cnt = 0;
        for (int i = 0; i < 832; i++) begin
            @(negedge clk);
            if (if_d.hsync == 1'b0) begin
                low_cnt++;
                if (low_first < 0) low_first = int'(if_d.x_px);
                low_last = int'(if_d.x_px);
            end
            if (if_d.activevideo == 1'b1) av_cnt++;
        end
        checkValue("hsync_low_cycles", low_cnt, 40);
        checkValue("hsync_first_x", low_first, 664);
        checkValue("hsync_last_x", low_last, 703);
        checkValue("line_active_cycles", av_cnt, 640);

        // Small raster 16x10, hsync active x=10..12, vsync active y=7..8.
        $display("[TB] small raster section");
        rst_s_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("s_reset", act_s(), pack(0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
        rst_s_n = 1'b1;
        fs_first = -1; fs_second = -1; fs_cnt = 0; vs_cnt = 0;
        for (int n = 1; n <= 320; n++) begin
            @(negedge clk);
            mx = n % 16;
            my = (n / 16) % 10;
            checkOutput("s_frame", act_s(),
                        pack(mx, my, (mx >= 10 && mx < 13), (my >= 7 && my < 9),
                             (mx < 8 && my < 6), (mx == 0 && my == 0)));
            if (if_s.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (n <= 160 && if_s.vsync == 1'b1) vs_cnt++;
        end
        checkValue("s_first_pulse_edge", fs_first, 160);
        checkValue("s_second_pulse_edge", fs_second, 320);
        checkValue("s_pulse_count", fs_cnt, 2);
        checkValue("s_vsync_cycles", vs_cnt, 32);

        // Abort mid-frame at (5,3) and confirm the next pulse is a full frame later.
        repeat (53) @(negedge clk);
        checkOutput("s_pre_abort", act_s(), pack(5, 3, 1'b0, 1'b0, 1'b1, 1'b0));
        rst_s_n = 1'b0;
        @(negedge clk);
        checkOutput("s_abort", act_s(), pack(0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
        rst_s_n = 1'b1;
        @(negedge clk);
        checkOutput("s_abort_next", act_s(), pack(1, 0, 1'b0, 1'b0, 1'b1, 1'b0));
        fs_first = -1; fs_cnt = 0;
        for (int k = 2; k <= 160; k++) begin
            @(negedge clk);
            if (if_s.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
            end
        end
        checkValue("s_abort_pulse_edge", fs_first, 160);
        checkValue("s_abort_pulse_count", fs_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 Parameter H_FRONT, default 24: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 40: hsync pulse width, in pixels.
REQ-004 Parameter H_BACK, default 128: horizontal back porch, in pixels; H_TOTAL = 832.
REQ-005 Parameter V_VISIBLE, default 480: active lines per frame.
REQ-006 Parameter V_FRONT, default 9: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 3: vsync pulse width, in lines.
REQ-008 Parameter V_BACK, default 28: vertical back porch, in lines; V_TOTAL = 520.
REQ-009 Parameter SYNC_POL, default 0: active level of hsync and vsync (0 = active-low).
REQ-010 Port clk, input, 1 bit: pixel clock (31.5 MHz nominal); the only clock.
REQ-011 Port reset_n, input, 1 bit: reset; one clock, reset is synchronous and active-low.
REQ-012 Port hsync, output, 1 bit: horizontal sync.
REQ-013 Port vsync, output, 1 bit: vertical sync.
REQ-014 Port x_px, output, 10 bits: current pixel column, 0..H_TOTAL-1.
REQ-015 Port y_px, output, 10 bits: current line, 0..V_TOTAL-1.
REQ-016 Port activevideo, output, 1 bit: high when the current pixel is visible.
REQ-017 Port frame_start, output, 1 bit: one-cycle strobe at pixel (0,0); used as the frame-rate clock enable for button logic.

Function
REQ-018 x_px SHALL increment by 1 every clk edge and wrap from H_TOTAL-1 to 0.
REQ-019 y_px SHALL increment by 1 on each x wrap and wrap from V_TOTAL-1 to 0 when x also wraps; otherwise y_px holds.
REQ-020 activevideo SHALL be 1 iff x_px < H_VISIBLE and y_px < V_VISIBLE.
REQ-021 hsync SHALL be at SYNC_POL iff H_VISIBLE+H_FRONT <= x_px < H_VISIBLE+H_FRONT+H_SYNC (default x = 664..703); otherwise it is at the inverse level.
REQ-022 vsync SHALL be at SYNC_POL iff V_VISIBLE+V_FRONT <= y_px < V_VISIBLE+V_FRONT+V_SYNC (default y = 489..491), for whole lines; otherwise it is at the inverse level.
REQ-023 frame_start SHALL be 1 iff x_px==0 and y_px==0, except in the cases defined by REQ-026.
REQ-024 hsync, vsync, activevideo and frame_start SHALL be registered, computed from next-state counter values, so they change only on clk edges and are exactly aligned with the x_px/y_px they describe (zero latency to the counters).
REQ-025 Counter arithmetic SHALL use 10-bit unsigned values; H_TOTAL and V_TOTAL SHALL each be at most 1024.

Reset
REQ-026 On any clk edge with reset_n low: x_px=0, y_px=0, hsync=vsync=inactive (1 at defaults), activevideo=1, frame_start=0. Reset asserted mid-frame SHALL abort the frame immediately. The first (0,0) after reset release SHALL NOT pulse frame_start; the first pulse comes one full frame later.
REQ-027 On the first edge with reset_n high, x_px SHALL become 1 (y_px=0), and counting SHALL continue normally.

Structure
REQ-028 H_*, V_*, the H_TOTAL/V_TOTAL derived constants and the 10-bit coordinate width SHALL live in a shared package vga_timing_pkg.
REQ-029 One sub-module vga_axis_counter (parameterised total, sync start/width, visible count, with enable input and wrap output) SHALL be instantiated once per axis, with the vertical instance enabled by the horizontal wrap.

Verification
REQ-030 Hold reset_n low 3 cycles -> x=0, y=0, hsync=1, vsync=1, activevideo=1, frame_start=0.
REQ-031 Release reset at (0,0) and count 639 edges -> x=639, activevideo=1; next edge -> x=640, activevideo=0.
REQ-032 Run one line -> hsync low for exactly 40 cycles, x=664..703, and high at x=704.
REQ-033 At x=831, y=519 -> next edge gives (0,0); frame_start=1 for 1 cycle; pulse period = 432640 cycles; no pulse at the first post-reset (0,0).
REQ-034 Run one frame -> vsync low for exactly 2496 cycles (y=489..491); activevideo=0 for all y>=480.
REQ-035 Assert reset_n low for 1 cycle at x=300, y=100 -> next edge x=0, y=0; the following edge x=1, y=0.
